// File: rtl/alu_share_arbiter_if.sv
// Handshake bundle between two ALU requesters, the shared-ALU arbiter and the result consumer.
// The master side is the requesters plus the consumer; the slave side is the arbiter.
interface alu_share_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [2:0]       req0_ctrl;
  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [2:0]       req1_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic             out_id;
  logic [31:0]      out_result;
  logic [3:0]       out_flags;
  logic             out_illegal;
  logic [CNT_W-1:0] grant0_cnt;
  logic [CNT_W-1:0] grant1_cnt;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_id, out_result, out_flags, out_illegal,
    input  grant0_cnt, grant1_cnt
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_id, out_result, out_flags, out_illegal,
    output grant0_cnt, grant1_cnt
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Results are held in a one-entry output register tagged with the requester id.
module alu_share_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus
);
  logic             r_prio;
  logic             r_out_valid;
  logic             r_out_id;
  logic [31:0]      r_out_result;
  logic [3:0]       r_out_flags;
  logic             r_out_illegal;
  logic [CNT_W-1:0] r_grant_cnt [2];

  logic [1:0]  w_valid;
  logic [1:0]  w_ready;
  logic        w_grant;
  logic        w_accept;
  logic        w_issue;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [2:0]  w_ctrl;
  logic [31:0] w_b_eff;
  logic [31:0] w_sum;
  logic        w_cout;
  logic [31:0] w_result;
  logic        w_carry;
  logic        w_ovf;
  logic [3:0]  w_flags;
  logic        w_illegal;

  assign w_valid  = {bus.req1_valid, bus.req0_valid};
  assign w_accept = !r_out_valid || bus.out_ready;

  // Contention falls to the priority pointer; a lone requester always wins.
  assign w_grant  = (w_valid == 2'b11) ? r_prio : w_valid[1];
  assign w_ready[0] = !w_grant && w_valid[0] && w_accept;
  assign w_ready[1] =  w_grant && w_valid[1] && w_accept;
  assign w_issue    = |w_ready;

  assign bus.req0_ready = w_ready[0];
  assign bus.req1_ready = w_ready[1];

  assign w_a    = w_grant ? bus.req1_a    : bus.req0_a;
  assign w_b    = w_grant ? bus.req1_b    : bus.req0_b;
  assign w_ctrl = w_grant ? bus.req1_ctrl : bus.req0_ctrl;

  // Shared ALU: ctrl[0] selects subtract as A + ~B + 1.
  assign w_b_eff         = w_ctrl[0] ? ~w_b : w_b;
  assign {w_cout, w_sum} = {1'b0, w_a} + {1'b0, w_b_eff} + {32'd0, w_ctrl[0]};

  always_comb begin
    w_result = 32'd0;
    case (w_ctrl)
      3'b000, 3'b001: w_result = w_sum;
      3'b010:         w_result = w_a & w_b;
      3'b011:         w_result = w_a | w_b;
      3'b101:         w_result = {31'd0, w_sum[31]};
      default:        w_result = 32'd0;
    endcase
  end

  assign w_carry   = w_cout & ~w_ctrl[1];
  assign w_ovf     = ~(w_ctrl[0] ^ w_a[31] ^ w_b[31]) & (w_a[31] ^ w_sum[31]) & ~w_ctrl[1];
  assign w_flags   = {w_result[31], (w_result == 32'd0), w_carry, w_ovf};
  assign w_illegal = w_ctrl[2] & (w_ctrl[1] | ~w_ctrl[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_id      <= 1'b0;
      r_out_result  <= 32'd0;
      r_out_flags   <= 4'd0;
      r_out_illegal <= 1'b0;
      r_prio        <= 1'b0;
    end else if (w_issue) begin
      r_out_valid   <= 1'b1;
      r_out_id      <= w_grant;
      r_out_result  <= w_result;
      r_out_flags   <= w_flags;
      r_out_illegal <= w_illegal;
      r_prio        <= ~w_grant;
    end else if (bus.out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_grant_cnt[gi] <= '0;
        end else if (w_ready[gi] && !(&r_grant_cnt[gi])) begin
          r_grant_cnt[gi] <= r_grant_cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign bus.out_valid   = r_out_valid;
  assign bus.out_id      = r_out_id;
  assign bus.out_result  = r_out_result;
  assign bus.out_flags   = r_out_flags;
  assign bus.out_illegal = r_out_illegal;
  assign bus.grant0_cnt  = r_grant_cnt[0];
  assign bus.grant1_cnt  = r_grant_cnt[1];
endmodule
